// File: rtl/maze_generator_param_pkg.sv
// Shared constants, FSM encoding and the LFSR step function for the maze generator.
package maze_pkg;

   localparam logic        WALL            = 1'b1;
   localparam logic        FLOOR           = 1'b0;
   localparam logic [15:0] LFSR_POLY       = 16'hB400;
   localparam logic        MODE_BTREE      = 1'b0;
   localparam logic        MODE_SIDEWINDER = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_CELL  = 3'd2,
      S_CARVE = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   // Right-shifting Galois step: the tap mask is applied when bit 0 shifts out.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ({1'b0, s[15:1]} ^ LFSR_POLY) : {1'b0, s[15:1]};
   endfunction

endpackage

// File: rtl/maze_generator_param_if.sv
// Control and tile-read bus between game control (master) and the maze generator (slave).
interface maze_generator_param_if #(
   parameter int SEED_W = 11,
   parameter int ADDR_W = 11
);
   logic              gen_start;
   logic              gen_mode;
   logic [SEED_W-1:0] seed;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_data;
   logic              busy;
   logic              gen_end;

   modport master (output gen_start, gen_mode, seed, rd_addr,
                   input  rd_data, busy, gen_end);
   modport slave  (input  gen_start, gen_mode, seed, rd_addr,
                   output rd_data, busy, gen_end);
endinterface

// File: rtl/maze_generator_param_lfsr16.sv
// 16-bit Galois LFSR with seed load (an all-zero seed becomes 1) and step enable.
module lfsr16
   import maze_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic        step,
   input  logic [15:0] seed,
   output logic [15:0] out
);

   logic [15:0] state_q;
   logic [15:0] state_d;

   // Next state: load wins over step.
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = (seed == 16'h0000) ? 16'h0001 : seed;
      end else if (step) begin
         state_d = lfsr_next(state_q);
      end else begin
         state_d = state_q;
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= 16'h0001;
      end else begin
         state_q <= state_d;
      end
   end

   assign out = state_q;

endmodule

// File: rtl/maze_generator_param.sv
// Perfect-maze generator: clears the tile RAM to WALL, then carves a spanning tree over the
// even/even cell lattice with binary-tree or sidewinder choices; tiles are read back after completion.
module maze_generator_param
   import maze_pkg::*;
#(
   parameter int WIDTH  = 31,
   parameter int HEIGHT = 41,
   parameter int SEED_W = 11,
   parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
   input logic                    clock,
   input logic                    reset,
   maze_generator_param_if.slave  bus
);

   localparam int DEPTH = WIDTH * HEIGHT;
   localparam int CW    = (WIDTH + 1) / 2;
   localparam int CH    = (HEIGHT + 1) / 2;
   localparam int MW    = (ADDR_W > 16) ? ADDR_W : 16;

   localparam logic [ADDR_W-1:0] ZERO_A   = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ONE_A    = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] LAST_CX  = ADDR_W'(CW - 1);
   localparam logic [ADDR_W-1:0] LAST_CY  = ADDR_W'(CH - 1);
   localparam logic [ADDR_W:0]   DEPTH_E  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   WIDTH_E  = (ADDR_W + 1)'(WIDTH);

   function automatic logic [ADDR_W-1:0] tile_addr(input logic [ADDR_W-1:0] x,
                                                   input logic [ADDR_W-1:0] y);
      logic [ADDR_W:0] p;
      p = ({1'b0, y} * WIDTH_E) + {1'b0, x};
      return ADDR_W'(p);
   endfunction

   state_e            state_q, state_d;
   logic              mode_q, mode_d;
   logic              busy_q, busy_d;
   logic              gen_end_q, gen_end_d;
   logic              rd_data_q, rd_data_d;
   logic [ADDR_W-1:0] clr_q, clr_d;
   logic [ADDR_W-1:0] cx_q, cx_d;
   logic [ADDR_W-1:0] cy_q, cy_d;
   logic [ADDR_W-1:0] run_q, run_d;
   logic [ADDR_W-1:0] pass_q, pass_d;

   logic [SEED_W-1:0] seed_s;
   logic [15:0]       lfsr_out_s;
   logic              lfsr_load_s;
   logic              wr_en_s;
   logic              wr_data_s;
   logic [ADDR_W-1:0] wr_addr_s;
   logic [ADDR_W-1:0] x2_s, y2_s, span_s, sw_col_s, north_col_s;
   logic [ADDR_W-1:0] cell_addr_s, east_addr_s, north_addr_s, pass_addr_s;
   logic [MW-1:0]     num_s, den_s, rem_s;
   logic              last_col_s, last_row_s, has_pass_s, go_north_s, close_run_s;
   logic [ADDR_W-1:0] nxt_cx_s, nxt_cy_s, nxt_run_s;
   state_e            adv_state_s;
   logic              adv_busy_s, adv_gen_end_s;

   logic mem [DEPTH];

   assign seed_s = bus.seed;

   lfsr16 u_lfsr (
      .clock (clock),
      .reset (reset),
      .load  (lfsr_load_s),
      .step  (busy_q),
      .seed  (16'(seed_s)),
      .out   (lfsr_out_s)
   );

   // Passage choice for the current cell; both algorithms share the shape, sidewinder
   // only differs in which column of the run gets the north opening.
   always_comb begin
      x2_s         = cx_q << 1'b1;
      y2_s         = cy_q << 1'b1;
      last_col_s   = (cx_q == LAST_CX);
      last_row_s   = (cy_q == LAST_CY);
      span_s       = cx_q - run_q + ONE_A;
      num_s        = MW'(lfsr_out_s[15:1]);
      den_s        = MW'(span_s);
      rem_s        = num_s % den_s;
      sw_col_s     = run_q + ADDR_W'(rem_s);
      close_run_s  = (mode_q == MODE_SIDEWINDER);
      north_col_s  = close_run_s ? sw_col_s : cx_q;
      cell_addr_s  = tile_addr(x2_s, y2_s);
      east_addr_s  = tile_addr(x2_s + ONE_A, y2_s);
      north_addr_s = tile_addr(north_col_s << 1'b1, y2_s - ONE_A);
      has_pass_s   = 1'b1;
      go_north_s   = 1'b0;
      if (cy_q == ZERO_A) begin
         has_pass_s = !last_col_s;
      end else if (last_col_s || lfsr_out_s[0]) begin
         go_north_s = 1'b1;
      end else begin
         go_north_s = 1'b0;
      end
      pass_addr_s = go_north_s ? north_addr_s : east_addr_s;
   end

   // Cell advance: row-major walk, finishing after the last cell.
   always_comb begin
      adv_state_s   = S_CELL;
      adv_busy_s    = 1'b1;
      adv_gen_end_s = 1'b0;
      nxt_cx_s      = cx_q + ONE_A;
      nxt_cy_s      = cy_q;
      nxt_run_s     = run_q;
      if (last_col_s) begin
         nxt_cx_s  = ZERO_A;
         nxt_cy_s  = cy_q + ONE_A;
         nxt_run_s = ZERO_A;
         if (last_row_s) begin
            adv_state_s   = S_DONE;
            adv_busy_s    = 1'b0;
            adv_gen_end_s = 1'b1;
         end else begin
            adv_state_s = S_CELL;
         end
      end else begin
         nxt_cx_s = cx_q + ONE_A;
      end
   end

   // Main FSM next-state and RAM write port.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      busy_d      = busy_q;
      gen_end_d   = gen_end_q;
      clr_d       = clr_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      run_d       = run_q;
      pass_d      = pass_q;
      lfsr_load_s = 1'b0;
      wr_en_s     = 1'b0;
      wr_addr_s   = clr_q;
      wr_data_s   = WALL;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.gen_start) begin
               mode_d      = bus.gen_mode;
               lfsr_load_s = 1'b1;
               clr_d       = ZERO_A;
               cx_d        = ZERO_A;
               cy_d        = ZERO_A;
               run_d       = ZERO_A;
               state_d     = S_CLEAR;
               busy_d      = 1'b1;
               gen_end_d   = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         S_CLEAR: begin
            wr_en_s = 1'b1;
            if (clr_q == LAST_CLR) begin
               state_d = S_CELL;
               cx_d    = ZERO_A;
               cy_d    = ZERO_A;
               run_d   = ZERO_A;
            end else begin
               clr_d = clr_q + ONE_A;
            end
         end
         S_CELL: begin
            wr_en_s   = 1'b1;
            wr_addr_s = cell_addr_s;
            wr_data_s = FLOOR;
            if (has_pass_s) begin
               pass_d  = pass_addr_s;
               state_d = S_CARVE;
               run_d   = (go_north_s && close_run_s) ? (cx_q + ONE_A) : run_q;
            end else begin
               state_d   = adv_state_s;
               busy_d    = adv_busy_s;
               gen_end_d = adv_gen_end_s;
               cx_d      = nxt_cx_s;
               cy_d      = nxt_cy_s;
               run_d     = nxt_run_s;
            end
         end
         S_CARVE: begin
            wr_en_s   = 1'b1;
            wr_addr_s = pass_q;
            wr_data_s = FLOOR;
            state_d   = adv_state_s;
            busy_d    = adv_busy_s;
            gen_end_d = adv_gen_end_s;
            cx_d      = nxt_cx_s;
            cy_d      = nxt_cy_s;
            run_d     = nxt_run_s;
         end
         default: begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            gen_end_d = 1'b0;
         end
      endcase
   end

   // Reads are hidden until a generation has completed, so partial mazes never leak out.
   always_comb begin
      rd_data_d = WALL;
      if (gen_end_q && !busy_q && ({1'b0, bus.rd_addr} < DEPTH_E)) begin
         rd_data_d = mem[bus.rd_addr];
      end else begin
         rd_data_d = WALL;
      end
   end

   // Tile RAM write port (contents survive reset).
   always_ff @(posedge clock) begin
      if (wr_en_s) begin
         mem[wr_addr_s] <= wr_data_s;
      end
   end

   // Control and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         mode_q    <= MODE_BTREE;
         busy_q    <= 1'b0;
         gen_end_q <= 1'b0;
         rd_data_q <= WALL;
         clr_q     <= ZERO_A;
         cx_q      <= ZERO_A;
         cy_q      <= ZERO_A;
         run_q     <= ZERO_A;
         pass_q    <= ZERO_A;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         busy_q    <= busy_d;
         gen_end_q <= gen_end_d;
         rd_data_q <= rd_data_d;
         clr_q     <= clr_d;
         cx_q      <= cx_d;
         cy_q      <= cy_d;
         run_q     <= run_d;
         pass_q    <= pass_d;
      end
   end

   assign bus.rd_data = rd_data_q;
   assign bus.busy    = busy_q;
   assign bus.gen_end = gen_end_q;

endmodule
